// File: rtl/sram_1mx8_if.sv
`default_nettype none
// ============================================================================
// Module  : sram_1mx8_if
// Purpose : User-side request bus of the 1M x 8 SRAM controller.
//           master = user logic, slave = controller.
// Rev     : 1.0  initial release
// ============================================================================
interface sram_1mx8_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8
);
  logic                  i_write;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_data;

  modport master (output i_write, i_addr, i_data, input o_data);
  modport slave  (input  i_write, i_addr, i_data, output o_data);
endinterface
`default_nettype wire

// File: rtl/sram_1mx8.sv
`default_nettype none
// ============================================================================
// Module  : sram_1mx8
// Purpose : Synchronous controller for an external asynchronous 1M x 8 SRAM.
//           Reads the addressed location continuously; a rising edge on
//           i_write runs one 3-cycle write (setup / pulse / hold).
// Rev     : 1.0  initial release
// ============================================================================
module sram_1mx8 #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8
) (
  input  wire                   i_clk,
  input  wire                   i_reset,
  sram_1mx8_if.slave            bus,
  output logic [ADDR_WIDTH-1:0] o_addr,
  inout  wire  [DATA_WIDTH-1:0] io_c_data,
  output logic                  o_n_oe,
  output logic                  o_n_we
);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_READ    = 3'd1;
  localparam logic [2:0] c_ST_W_SETUP = 3'd2;
  localparam logic [2:0] c_ST_W_PULSE = 3'd3;
  localparam logic [2:0] c_ST_W_HOLD  = 3'd4;

  logic [2:0]            r_state;
  logic [2:0]            w_next_state;
  logic                  r_write_d;
  logic                  w_wr_edge;

  logic [ADDR_WIDTH-1:0] r_addr,  w_addr;
  logic [DATA_WIDTH-1:0] r_data,  w_data;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata;
  logic                  r_n_oe,  w_n_oe;
  logic                  r_n_we,  w_n_we;
  logic                  r_drive, w_drive;

  // A write starts only on a fresh 0->1 of i_write; the sample runs every cycle.
  assign w_wr_edge = bus.i_write & ~r_write_d;

  // State and all pin-facing outputs are registered together so pins change on one edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= c_ST_IDLE;
      r_write_d <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_wdata   <= '0;
      r_n_oe    <= 1'b1;
      r_n_we    <= 1'b1;
      r_drive   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_write_d <= bus.i_write;
      r_addr    <= w_addr;
      r_data    <= w_data;
      r_wdata   <= w_wdata;
      r_n_oe    <= w_n_oe;
      r_n_we    <= w_n_we;
      r_drive   <= w_drive;
    end
  end

  // Next state: write edges are honoured only from IDLE or READ, never queued.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      c_ST_IDLE:    w_next_state = w_wr_edge ? c_ST_W_SETUP : c_ST_READ;
      c_ST_READ:    w_next_state = w_wr_edge ? c_ST_W_SETUP : c_ST_READ;
      c_ST_W_SETUP: w_next_state = c_ST_W_PULSE;
      c_ST_W_PULSE: w_next_state = c_ST_W_HOLD;
      c_ST_W_HOLD:  w_next_state = c_ST_READ;
      default:      w_next_state = c_ST_IDLE;
    endcase
  end

  // Output values for the state being entered; the turnaround in W_SETUP keeps OE and bus drive apart.
  always_comb begin
    w_addr  = r_addr;
    w_data  = r_data;
    w_wdata = r_wdata;
    w_n_oe  = r_n_oe;
    w_n_we  = 1'b1;
    w_drive = 1'b0;
    unique case (w_next_state)
      c_ST_READ: begin
        w_addr = bus.i_addr;
        w_n_oe = 1'b0;
        // Only a READ cycle has the chip driving valid data for the previous address.
        if (r_state == c_ST_READ) w_data = io_c_data;
      end
      c_ST_W_SETUP: begin
        w_addr  = bus.i_addr;
        w_wdata = bus.i_data;
        w_n_oe  = 1'b1;
      end
      c_ST_W_PULSE: begin
        w_n_we  = 1'b0;
        w_drive = 1'b1;
      end
      c_ST_W_HOLD: begin
        w_drive = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_addr     = r_addr;
  assign o_n_oe     = r_n_oe;
  assign o_n_we     = r_n_we;
  assign bus.o_data = r_data;
  assign io_c_data  = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_sram_1mx8.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_1mx8
// Purpose : Self-checking bench for sram_1mx8 with an async SRAM pin model
//           and a cycle-level behavioural reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sram_1mx8;
  localparam int AW = 20;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_1mx8_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  logic [AW-1:0] o_addr;
  wire  [DW-1:0] c_data;
  logic          o_n_oe;
  logic          o_n_we;

  sram_1mx8 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk    (clk),
    .i_reset  (rst_n),
    .bus      (bus_if),
    .o_addr   (o_addr),
    .io_c_data(c_data),
    .o_n_oe   (o_n_oe),
    .o_n_we   (o_n_we)
  );

  // Asynchronous SRAM on the pins: drives when OE low and WE high, stores while WE low.
  logic [DW-1:0] pins_mem [0:(1<<AW)-1];
  assign c_data = (!o_n_oe && o_n_we) ? pins_mem[o_addr] : {DW{1'bz}};

  always @(negedge clk) begin
    if (o_n_we === 1'b0) pins_mem[o_addr] <= c_data;
  end

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the chip should hold and what the pins should show.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  bit            m_valid   = 0;
  bit            m_prev_wr = 0;
  bit            m_reading = 0;
  int            m_wcnt    = 0;  // write cycles still to come: 3 setup, 2 pulse, 1 hold
  logic [AW-1:0] m_addr    = '0;
  logic [DW-1:0] m_data    = '0;
  logic [DW-1:0] m_wdata   = '0;
  logic          m_noe     = 1'b1;
  logic          m_nwe     = 1'b1;
  bit            m_drive   = 0;

  // Advance the reference model on each rising edge using the applied inputs.
  always @(posedge clk) begin
    bit got_edge;
    if (!rst_n) begin
      m_valid = 1; m_prev_wr = 0; m_reading = 0; m_wcnt = 0;
      m_addr = '0; m_data = '0; m_noe = 1'b1; m_nwe = 1'b1; m_drive = 0;
    end else begin
      got_edge  = bus_if.i_write && !m_prev_wr;
      m_prev_wr = bus_if.i_write;
      if (m_wcnt == 3) begin
        m_wcnt = 2; m_nwe = 1'b0; m_drive = 1;
        ref_mem[m_addr] = m_wdata;
      end else if (m_wcnt == 2) begin
        m_wcnt = 1; m_nwe = 1'b1;
      end else if (m_wcnt == 0 && got_edge) begin
        m_wcnt = 3; m_addr = bus_if.i_addr; m_wdata = bus_if.i_data;
        m_noe = 1'b1; m_reading = 0; m_drive = 0;
      end else begin
        if (m_reading) m_data = ref_rd(m_addr);
        m_wcnt = 0; m_addr = bus_if.i_addr; m_noe = 1'b0; m_reading = 1; m_drive = 0;
      end
    end
  end

  // Compare DUT pins with the model mid-cycle, and count write pulse cycles.
  always @(negedge clk) begin
    if (o_n_we === 1'b0) pulse_cnt++;
    if (m_valid) begin
      chk("o_addr", 32'(o_addr), 32'(m_addr));
      chk("o_data", 32'(bus_if.o_data), 32'(m_data));
      chk("o_n_oe", 32'(o_n_oe), 32'(m_noe));
      chk("o_n_we", 32'(o_n_we), 32'(m_nwe));
      chk("oe_we_not_both_low", 32'(o_n_oe | o_n_we), 32'd1);
      if (m_drive) chk("bus_write_data", 32'(c_data), 32'(m_wdata));
      if (!m_noe)  chk("bus_read_no_contention", 32'(c_data), 32'(ref_rd(m_addr)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_op(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_if.i_addr = a; bus_if.i_data = d; bus_if.i_write = 1'b1;
    cyc();
    bus_if.i_write = 1'b0;
    cyc(); cyc(); cyc();
  endtask

  task automatic rd_op(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bus_if.i_addr = a;
    cyc(); cyc();
    d = bus_if.o_data;
  endtask

  logic [AW-1:0] pool [8];
  logic [DW-1:0] rdv;
  int            pc0;

  // Directed scenarios first, then a randomized run against the model.
  initial begin
    for (int i = 0; i < (1<<AW); i++) pins_mem[i] = '0;
    pool = '{20'h00000, 20'hFFFFF, 20'h12345, 20'h00777, 20'h80000, 20'h0FFFF, 20'h5555A, 20'h00001};
    bus_if.i_write = 1'b0; bus_if.i_addr = '0; bus_if.i_data = '0;
    rst_n = 1'b0;

    for (int i = 0; i < 3; i++) begin
      bus_if.i_write = 1'($urandom); bus_if.i_addr = AW'($urandom); bus_if.i_data = DW'($urandom);
      cyc();
      chk("reset_o_addr", 32'(o_addr), 32'h0);
      chk("reset_o_data", 32'(bus_if.o_data), 32'h0);
      chk("reset_n_oe",   32'(o_n_oe), 32'h1);
      chk("reset_n_we",   32'(o_n_we), 32'h1);
    end
    rst_n = 1'b1; bus_if.i_write = 1'b0;
    cyc();
    chk("first_read_n_oe", 32'(o_n_oe), 32'h0);

    bus_if.i_addr = 20'h12345; bus_if.i_data = 8'hA5; bus_if.i_write = 1'b1;
    cyc();
    chk("setup_addr", 32'(o_addr), 32'h12345);
    chk("setup_n_oe", 32'(o_n_oe), 32'h1);
    chk("setup_n_we", 32'(o_n_we), 32'h1);
    bus_if.i_write = 1'b0;
    pc0 = pulse_cnt;
    cyc();
    chk("pulse_n_we", 32'(o_n_we), 32'h0);
    chk("pulse_bus",  32'(c_data), 32'hA5);
    cyc();
    chk("hold_n_we",  32'(o_n_we), 32'h1);
    chk("hold_bus",   32'(c_data), 32'hA5);
    chk("hold_addr",  32'(o_addr), 32'h12345);
    cyc();
    chk("resume_n_oe", 32'(o_n_oe), 32'h0);
    cyc();
    chk("readback_A5", 32'(bus_if.o_data), 32'hA5);
    chk("single_pulse_len", 32'(pulse_cnt - pc0), 32'd1);

    pc0 = pulse_cnt;
    bus_if.i_addr = 20'h0ABCD; bus_if.i_data = 8'h11; bus_if.i_write = 1'b1;
    repeat (10) cyc();
    bus_if.i_write = 1'b0;
    cyc(); cyc();
    chk("held_write_pulses", 32'(pulse_cnt - pc0), 32'd1);

    pc0 = pulse_cnt;
    bus_if.i_addr = 20'h00777; bus_if.i_data = 8'h3C; bus_if.i_write = 1'b1;
    cyc();
    bus_if.i_write = 1'b0;
    cyc();
    bus_if.i_write = 1'b1; bus_if.i_data = 8'hC3;
    cyc(); cyc();
    bus_if.i_write = 1'b0;
    cyc(); cyc();
    chk("write_in_write_pulses", 32'(pulse_cnt - pc0), 32'd1);
    rd_op(20'h00777, rdv);
    chk("write_in_write_data", 32'(rdv), 32'h3C);

    wr_op(20'hFFFFF, 8'hFF);
    wr_op(20'h00000, 8'h00);
    rd_op(20'hFFFFF, rdv);
    chk("top_addr_data", 32'(rdv), 32'hFF);
    rd_op(20'h00000, rdv);
    chk("zero_addr_data", 32'(rdv), 32'h00);

    bus_if.i_addr = 20'h5555A; bus_if.i_data = 8'h5A; bus_if.i_write = 1'b1;
    cyc();
    bus_if.i_write = 1'b0;
    cyc();
    chk("abort_in_pulse", 32'(o_n_we), 32'h0);
    rst_n = 1'b0;
    cyc();
    chk("abort_n_we",   32'(o_n_we), 32'h1);
    chk("abort_n_oe",   32'(o_n_oe), 32'h1);
    chk("abort_o_addr", 32'(o_addr), 32'h0);
    chk("abort_o_data", 32'(bus_if.o_data), 32'h0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 800; i++) begin
      rst_n          = ($urandom_range(0, 59) != 0);
      bus_if.i_write = ($urandom_range(0, 3) == 0);
      bus_if.i_addr  = pool[$urandom_range(0, 7)];
      bus_if.i_data  = DW'($urandom);
      cyc();
    end
    rst_n = 1'b1; bus_if.i_write = 1'b0;
    repeat (4) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_1mx8.md
Name: sram_1mx8

Overview:
- Synchronous controller for an external asynchronous 1M x 8 SRAM (10 ns class).
- Converts a simple internal read/write request interface into chip pins: address bus, bidirectional data bus, active-low output enable and write enable.
- Sits between user logic and the top-level SRAM pins.
- With no write request, continuously reads the addressed location.

Parameters:
- ADDR_WIDTH, 20: width of the internal and chip address buses (1M locations).
- DATA_WIDTH, 8: width of the internal and chip data buses.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-low reset (0 = reset).
- i_write  in  1  write request; a 0->1 transition starts one write.
- i_addr  in  ADDR_WIDTH  address for read or write.
- i_data  in  DATA_WIDTH  write data.
- o_data  out  DATA_WIDTH  registered read data.
- o_addr  out  ADDR_WIDTH  registered address to chip pins.
- io_c_data  inout  DATA_WIDTH  chip data bus; driven only during write, else high-Z.
- o_n_oe  out  1  chip output enable, active low, registered.
- o_n_we  out  1  chip write enable, active low, registered.

Behaviour:
- Reset is synchronous and active-low: i_reset = 0 at a rising edge forces the following:
  - state = IDLE
  - o_addr = 0, o_data = 0
  - o_n_oe = 1, o_n_we = 1
  - io_c_data high-Z
  - write-edge register = 0
- Reset mid-write aborts the write immediately (o_n_we = 1, bus released).
- States: IDLE, READ, W_SETUP, W_PULSE, W_HOLD.
- IDLE (one cycle after reset release): o_n_oe = 1. Next state is READ, or W_SETUP if a write edge is detected.
- Write edge: i_write = 1 while the previous-cycle sample of i_write = 0. The sample register updates every cycle, including during writes. A held-high i_write yields exactly one write.
- READ:
  - Each cycle: o_addr <= i_addr, o_n_oe <= 0, o_n_we = 1, bus high-Z.
  - o_data <= io_c_data, i.e. data for the address presented the previous cycle.
  - Read latency: i_addr sampled at edge N; o_data valid after edge N+1 (2 cycles).
  - o_data holds its last value outside READ.
- Write sequence, 3 cycles:
  - W_SETUP: capture i_addr -> o_addr and i_data -> internal write register. o_n_oe <= 1, o_n_we = 1, bus still high-Z (turnaround cycle).
  - W_PULSE: drive io_c_data = write register, o_n_we <= 0, address stable.
  - W_HOLD: o_n_we <= 1, data still driven, address stable.
  - Then READ. Bus released on entry to READ; o_n_oe goes low the same edge. The first read resumes at the current i_addr.
- Write edges occurring during W_SETUP/W_PULSE/W_HOLD are ignored (no queueing).
- A write edge in READ takes priority over the read. That cycle's o_data is not updated.
- o_n_oe and o_n_we are never both 0. io_c_data is never driven while o_n_oe = 0.
- No address arithmetic. Addresses pass through unmodified; all ADDR_WIDTH bits are used, with no wrap logic.
- Clock period must be at least the SRAM tAA plus the pad delay; 12–50 MHz is the target.

Test Plan:
- Reset: i_reset = 0 for 3 cycles with random inputs -> o_addr = 0, o_data = 0, o_n_oe = 1, o_n_we = 1, io_c_data = Z. Release -> IDLE one cycle, then o_n_oe = 0.
- Write then read: with a behavioural async SRAM model on the pins, write 0xA5 to 0x12345 -> o_n_we low for exactly 1 cycle with o_addr = 0x12345 and io_c_data = 0xA5 in W_PULSE and W_HOLD. Then set i_addr = 0x12345 -> o_data = 0xA5 two cycles later.
- Held write: i_write held high for 10 cycles -> exactly one o_n_we low pulse.
- Write during write: second 0->1 i_write edge in W_PULSE -> ignored, only one pulse. The model location holds the first data only.
- Address extremes: write 0x00 to 0x00000 and 0xFF to 0xFFFFF, read both back -> 0x00 and 0xFF. No aliasing.
- Reset mid-write: assert i_reset during W_PULSE -> next edge o_n_we = 1, bus Z, all outputs at reset values. Bus contention checker flags no overlap of driven io_c_data with o_n_oe = 0 throughout.
